async_xing_arb: RTL and testbench

ASYNC_XING_ARB -- requirements
Module: async_xing_arb

---
 rtl/async_xing_arb_if.sv | 36 +++
 rtl/async_xing_arb.sv | 119 +++++++++++
 tb/tb_async_xing_arb.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/async_xing_arb_if.sv
`default_nettype none
// ============================================================================
//  Module   : async_xing_arb_if
//  Purpose  : Request/enqueue bundle between requesters, the crossing
//             arbiter and the asynchronous-queue source side.
//  Revision : 1.0 - initial release
// ============================================================================
interface async_xing_arb_if #(
    parameter int NREQ = 4,
    parameter int W    = 15
);
    localparam int c_IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_bits;
    logic [NREQ-1:0]   req_ready;
    logic              enq_valid;
    logic [W-1:0]      enq_bits;
    logic [c_IDW-1:0]  enq_id;
    logic              enq_ready;
    logic              sink_reset;
    logic [7:0]        drop_cnt;

    // Arbiter side: accepts requests, drives the queue enqueue port.
    modport master (
        input  req_valid, req_bits, enq_ready, sink_reset,
        output req_ready, enq_valid, enq_bits, enq_id, drop_cnt
    );

    // Environment side: requesters, queue source and reset synchronizer.
    modport slave (
        output req_valid, req_bits, enq_ready, sink_reset,
        input  req_ready, enq_valid, enq_bits, enq_id, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/async_xing_arb.sv
`default_nettype none
// ============================================================================
//  Module   : async_xing_arb
//  Purpose  : Round-robin arbiter feeding a single-entry hold stage into the
//             source side of an asynchronous queue; flushes the held item
//             when the remote domain is in reset.
//  Revision : 1.0 - initial release
// ============================================================================
module async_xing_arb #(
    parameter int NREQ = 4,
    parameter int W    = 15
) (
    input  wire logic          clock,
    input  wire logic          reset_n,
    async_xing_arb_if.master   bus
);
    localparam int c_IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [c_IDW:0]   c_NREQ_X = (c_IDW+1)'(NREQ);
    localparam logic [c_IDW-1:0] c_LAST_INIT = c_IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t           r_state;
    logic [c_IDW-1:0] r_last_grant;
    logic [W-1:0]     r_hold_bits;
    logic [c_IDW-1:0] r_hold_id;
    logic [7:0]       r_drop_cnt;

    logic             w_slot_free;
    logic             w_found;
    logic             w_grant;
    logic [c_IDW-1:0] w_gnt_idx;
    logic [c_IDW:0]   w_scan;
    logic [W-1:0]     w_gnt_bits;
    logic [NREQ-1:0]  w_ready;

    // Hold slot can take a new item when empty or draining this cycle.
    // Gated by reset_n so nothing is accepted while the block is held in reset.
    assign w_slot_free = (r_state == S_IDLE) || ((r_state == S_SEND) && bus.enq_ready);
    assign w_grant     = w_found && w_slot_free && !bus.sink_reset && reset_n;

    // Round-robin scan starting just after the last granted requester.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_scan    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_scan = {1'b0, r_last_grant} + (c_IDW+1)'(k);
            if (w_scan >= c_NREQ_X) begin
                w_scan = w_scan - c_NREQ_X;
            end
            if (!w_found && bus.req_valid[w_scan[c_IDW-1:0]]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_scan[c_IDW-1:0];
            end
        end
    end

    // Decode the winner into its ready strobe and payload.
    always_comb begin
        w_ready    = '0;
        w_gnt_bits = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_idx == c_IDW'(i)) begin
                w_ready[i] = w_grant;
                w_gnt_bits = bus.req_bits[i*W +: W];
            end
        end
    end

    assign bus.req_ready = w_ready;
    // Drops in the same cycle as sink_reset so a dying remote never sees a push.
    assign bus.enq_valid = (r_state == S_SEND) && !bus.sink_reset;
    assign bus.enq_bits  = r_hold_bits;
    assign bus.enq_id    = r_hold_id;
    assign bus.drop_cnt  = r_drop_cnt;

    // State machine, hold registers, priority pointer and drop counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= c_LAST_INIT;
            r_hold_bits  <= '0;
            r_hold_id    <= '0;
            r_drop_cnt   <= '0;
        end else if (bus.sink_reset) begin
            // enq_valid is low under sink_reset, so a held item can never fire here.
            r_state <= S_FLUSH;
            if ((r_state == S_SEND) && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end else begin
            case (r_state)
                S_FLUSH: begin
                    r_state      <= S_IDLE;
                    r_last_grant <= c_LAST_INIT;
                end
                S_IDLE, S_SEND: begin
                    if (w_grant) begin
                        r_state      <= S_SEND;
                        r_hold_bits  <= w_gnt_bits;
                        r_hold_id    <= w_gnt_idx;
                        r_last_grant <= w_gnt_idx;
                    end else if ((r_state == S_SEND) && bus.enq_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_async_xing_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_async_xing_arb
//  Purpose  : Directed self-checking bench for async_xing_arb, ending with a
//             random section checked against a small round-robin model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_async_xing_arb;
    localparam int NREQ = 4;
    localparam int W    = 15;

    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    async_xing_arb_if #(.NREQ(NREQ), .W(W)) bus ();

    async_xing_arb #(.NREQ(NREQ), .W(W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_bits(input int i, input logic [W-1:0] v);
        bus.req_bits[i*W +: W] = v;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Random-phase model state
    int          m_last;
    bit          m_busy;
    int          m_id;
    logic [W-1:0] m_bits;
    int          m_g;
    logic [3:0]  m_ready;
    logic [W-1:0] m_cur_bits [NREQ];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        bus.req_valid  = 4'hF;
        bus.req_bits   = '0;
        bus.enq_ready  = 1'b0;
        bus.sink_reset = 1'b0;

        // ---- reset state ----
        step();
        step();
        chk("rst_enq_valid", 32'(bus.enq_valid), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_enq_id",    32'(bus.enq_id),    32'd0);
        chk("rst_enq_bits",  32'(bus.enq_bits),  32'd0);
        chk("rst_drop_cnt",  32'(bus.drop_cnt),  32'd0);

        // ---- all requesting, queue always ready: 0,1,2,3,0 ----
        for (int i = 0; i < NREQ; i++) set_bits(i, 15'(16'h100 + i));
        reset_n       = 1'b1;
        bus.enq_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_req_ready", 32'(bus.req_ready), 32'(1 << (k % 4)));
            step();
            chk("rr_enq_valid", 32'(bus.enq_valid), 32'd1);
            chk("rr_enq_id",    32'(bus.enq_id),    32'(k % 4));
            chk("rr_enq_bits",  32'(bus.enq_bits),  32'(16'h100 + (k % 4)));
        end
        bus.req_valid = 4'h0;
        #1;
        chk("drain_req_ready", 32'(bus.req_ready), 32'd0);
        step();
        chk("drain_enq_valid", 32'(bus.enq_valid), 32'd0);
        chk("drain_hold_id",   32'(bus.enq_id),    32'd0);
        chk("drain_hold_bits", 32'(bus.enq_bits),  32'h100);

        // ---- stalled queue holds payload stable ----
        bus.req_valid = 4'b0100;
        bus.enq_ready = 1'b0;
        set_bits(2, 15'h1ABC);
        #1;
        chk("stall_grant", 32'(bus.req_ready), 32'b0100);
        step();
        for (int k = 0; k < 5; k++) begin
            chk("stall_enq_valid", 32'(bus.enq_valid), 32'd1);
            chk("stall_enq_bits",  32'(bus.enq_bits),  32'h1ABC);
            chk("stall_enq_id",    32'(bus.enq_id),    32'd2);
            chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
            step();
        end

        // ---- flush with a held item ----
        bus.sink_reset = 1'b1;
        bus.req_valid  = 4'hF;
        bus.enq_ready  = 1'b1;
        #1;
        chk("flush_enq_valid_now", 32'(bus.enq_valid), 32'd0);
        chk("flush_req_ready_now", 32'(bus.req_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("flush_req_ready", 32'(bus.req_ready), 32'd0);
            chk("flush_enq_valid", 32'(bus.enq_valid), 32'd0);
            chk("flush_drop_cnt",  32'(bus.drop_cnt),  32'd1);
        end
        bus.sink_reset = 1'b0;
        #1;
        chk("flush_exit_req_ready", 32'(bus.req_ready), 32'd0);
        step();
        chk("post_flush_prio0", 32'(bus.req_ready), 32'b0001);
        step();
        chk("post_flush_id",   32'(bus.enq_id),   32'd0);
        chk("post_flush_bits", 32'(bus.enq_bits), 32'h100);
        bus.req_valid = 4'h0;
        step();

        // ---- drop counter saturation: 299 more flushes ----
        bus.req_valid = 4'b0001;
        bus.enq_ready = 1'b0;
        for (int i = 0; i < 299; i++) begin
            step();
            bus.sink_reset = 1'b1;
            step();
            bus.sink_reset = 1'b0;
            if (i == 252) chk("drop_cnt_254", 32'(bus.drop_cnt), 32'd254);
            step();
        end
        bus.req_valid = 4'h0;
        chk("drop_cnt_sat", 32'(bus.drop_cnt), 32'd255);

        // ---- asynchronous reset in SEND ----
        bus.req_valid = 4'b0001;
        step();
        chk("areset_pre_valid", 32'(bus.enq_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_enq_valid", 32'(bus.enq_valid), 32'd0);
        chk("areset_enq_id",    32'(bus.enq_id),    32'd0);
        chk("areset_enq_bits",  32'(bus.enq_bits),  32'd0);
        chk("areset_drop_cnt",  32'(bus.drop_cnt),  32'd0);
        bus.req_valid = 4'b0010;
        #1;
        chk("areset_req_ready", 32'(bus.req_ready), 32'd0);
        step();
        reset_n = 1'b1;
        #1;
        chk("release_grant",     32'(bus.req_ready), 32'b0010);
        chk("release_idle",      32'(bus.enq_valid), 32'd0);
        step();
        chk("release_enq_valid", 32'(bus.enq_valid), 32'd1);
        chk("release_enq_id",    32'(bus.enq_id),    32'd1);
        chk("release_enq_bits",  32'(bus.enq_bits),  32'h101);
        bus.req_valid = 4'h0;
        bus.enq_ready = 1'b1;
        step();
        chk("release_done", 32'(bus.enq_valid), 32'd0);

        // ---- random traffic against a reference round-robin model ----
        m_last = 1;
        m_busy = 1'b0;
        m_id   = 1;
        m_bits = 15'h101;
        for (int c = 0; c < 400; c++) begin
            bus.req_valid = 4'($urandom);
            bus.enq_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                m_cur_bits[i] = 15'($urandom);
                set_bits(i, m_cur_bits[i]);
            end
            #1;
            m_g     = -1;
            m_ready = 4'b0;
            if (!m_busy || bus.enq_ready) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (m_g < 0 && bus.req_valid[(m_last + k) % NREQ]) m_g = (m_last + k) % NREQ;
                end
                if (m_g >= 0) m_ready[m_g] = 1'b1;
            end
            chk("rand_cycle",
                {10'd0, bus.req_ready, bus.enq_valid, bus.enq_id, bus.enq_bits},
                {10'd0, m_ready, m_busy, 2'(m_id), m_bits});
            step();
            if (m_g >= 0) begin
                m_busy = 1'b1;
                m_id   = m_g;
                m_bits = m_cur_bits[m_g];
                m_last = m_g;
            end else if (bus.enq_ready) begin
                m_busy = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
